// File: rtl/tstamp_tx_sequencer.sv
// Frames a timestamp snapshot as header + 4 bytes (+ optional XOR checksum) and
// sequences it onto a UART Tx via start/done handshake. Optional: TSEQ_CHECKSUM_EN.
module tstamp_tx_sequencer #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         TS_W        = 26,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            report_req,
    input  logic            force_send,
    input  logic [TS_W-1:0] tstamp,
    input  logic            tx_busy,
    input  logic            tx_done,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic            frame_active,
    output logic            frame_done,
    output logic            timeout_err,
    input  logic            err_clr,
    output logic [7:0]      drop_cnt,
    output logic [2:0]      state_dbg
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

`ifdef TSEQ_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    logic            rr_s1, rr_s2, rr_s3;
    logic            req_evt;
    logic            pending;
    logic [2:0]      idx;
    logic [31:0]     snap;
    logic [WD_W-1:0] wd;
    logic [7:0]      cur_byte;

    assign state_dbg = state;

    // report_req comes from the ticker domain: two sync stages, then a third
    // stage purely for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_s1 <= 1'b0;
            rr_s2 <= 1'b0;
            rr_s3 <= 1'b0;
        end else begin
            rr_s1 <= report_req;
            rr_s2 <= rr_s1;
            rr_s3 <= rr_s2;
        end
    end

    assign req_evt = (rr_s2 & ~rr_s3) | force_send;

`ifdef TSEQ_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (state == LOAD) begin
            csum <= 8'h00;
        end else if (state == SEND && !tx_busy) begin
            csum <= csum ^ cur_byte;
        end
    end
`endif

    // Frame bytes, MSB first; the snapshot is zero-padded so b1 carries the top bits.
    always_comb begin
        cur_byte = HEADER_BYTE;
        case (idx)
            3'd0:    cur_byte = HEADER_BYTE;
            3'd1:    cur_byte = snap[31:24];
            3'd2:    cur_byte = snap[23:16];
            3'd3:    cur_byte = snap[15:8];
            3'd4:    cur_byte = snap[7:0];
`ifdef TSEQ_CHECKSUM_EN
            3'd5:    cur_byte = csum;
`endif
            default: cur_byte = HEADER_BYTE;
        endcase
    end

    // Tx handshake: tx_start is a one-cycle pulse with tx_data valid; tx_data
    // stays put until the Tx answers with a one-cycle tx_done (or the watchdog
    // aborts). tx_done outside WAIT is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
            drop_cnt     <= 8'h00;
            pending      <= 1'b0;
            idx          <= 3'd0;
            snap         <= 32'h0;
            wd           <= '0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;

            // A later timeout assignment in this block overrides the clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            if (state != IDLE && req_evt) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (req_evt || pending) begin
                        state        <= LOAD;
                        frame_active <= 1'b1;
                        // Serving a queued request while a new one arrives
                        // keeps the new one queued.
                        pending      <= pending & req_evt;
                    end
                end
                LOAD: begin
                    snap  <= 32'(tstamp);
                    idx   <= 3'd0;
                    state <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= cur_byte;
                        wd       <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end else if (wd == WD_MAX) begin
                        timeout_err  <= 1'b1;
                        tx_data      <= 8'h00;
                        frame_active <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    frame_done   <= 1'b1;
                    frame_active <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    frame_active <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tstamp_tx_sequencer.sv
// Bench for tstamp_tx_sequencer: Tx responder model, byte scoreboard, latency,
// queuing/drop, watchdog and reset checks.
module tb_tstamp_tx_sequencer;

    localparam int TO_CYC = 16;
    localparam int TX_DLY = 12;

    logic        clk;
    logic        rst_n;
    logic        report_req;
    logic        force_send;
    logic [25:0] tstamp;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_active;
    logic        frame_done;
    logic        timeout_err;
    logic        err_clr;
    logic [7:0]  drop_cnt;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int starts_seen = 0;
    logic tx_auto = 1'b1;
    logic [7:0] exp_q[$];

    tstamp_tx_sequencer #(
        .HEADER_BYTE (8'hA5),
        .TS_W        (26),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .report_req   (report_req),
        .force_send   (force_send),
        .tstamp       (tstamp),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr),
        .drop_cnt     (drop_cnt),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [25:0] ts);
        logic [7:0] b [5];
        logic [7:0] x;
        b[0] = 8'hA5;
        b[1] = {6'b0, ts[25:24]};
        b[2] = ts[23:16];
        b[3] = ts[15:8];
        b[4] = ts[7:0];
        x = 8'h00;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(b[i]);
            x = x ^ b[i];
        end
`ifdef TSEQ_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_force();
        force_send = 1'b1;
        tick(1);
        force_send = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check("frame_wait", 32'(done_cnt), 32'(target));
    endtask

    // Tx responder and scoreboard consumer
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tx_start) begin
                starts_seen++;
                check("start_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                if (tx_auto) begin
                    repeat (TX_DLY - 1) @(posedge clk);
                    #1 tx_done = 1'b1;
                    @(posedge clk);
                    #1 tx_done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        int base;
        int hits;
        int n;
        rst_n      = 1'b0;
        report_req = 1'b0;
        force_send = 1'b0;
        tstamp     = 26'h2ABCDEF;
        tx_busy    = 1'b0;
        err_clr    = 1'b0;
        tick(3);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // basic frame via force_send, latency k+2
        push_frame(tstamp);
        pulse_force();
        check("t1_active", 32'(frame_active), 32'd1);
        tick(1);
        check("t1_start_early", 32'(tx_start), 32'd0);
        tick(1);
        check("t1_start_lat", 32'(tx_start), 32'd1);
        wait_frames(1, 400);
        tick(2);
        check("t1_active_end", 32'(frame_active), 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // report_req rising edge, latency k+4, level hold gives one frame
        tstamp = 26'h0123456;
        push_frame(tstamp);
        report_req = 1'b1;
        tick(4);
        check("t2_start_early", 32'(tx_start), 32'd0);
        tick(1);
        check("t2_start_lat", 32'(tx_start), 32'd1);
        wait_frames(2, 400);
        tick(80);
        check("t2_no_refire", 32'(done_cnt), 32'd2);
        check("t2_idle", 32'(frame_active), 32'd0);
        report_req = 1'b0;
        tick(4);

        // queued follow-on frame takes the timestamp present at its LOAD
        tstamp = 26'h1234567;
        push_frame(tstamp);
        pulse_force();
        tick(5);
        tstamp = 26'h3FEDCBA;
        push_frame(tstamp);
        pulse_force();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            pulse_force();
        end
        check("t3_drop3", 32'(drop_cnt), 32'd3);
        wait_frames(4, 800);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // tx_busy held in SEND, drop counter saturation
        tick(2);
        tx_busy = 1'b1;
        push_frame(tstamp);
        push_frame(tstamp);
        force_send = 1'b1;
        hits = 0;
        for (int i = 0; i < 302; i++) begin
            tick(1);
            if (tx_start) hits++;
        end
        force_send = 1'b0;
        check("t3_drop_sat", 32'(drop_cnt), 32'd255);
        check("t5_busy_state", 32'(state_dbg), 32'd2);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (tx_start) hits++;
        end
        check("t5_no_start_busy", 32'(hits), 32'd0);
        tx_busy = 1'b0;
        tick(1);
        check("t5_start_after_busy", 32'(tx_start), 32'd1);
        wait_frames(6, 800);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);
        check("t3_drop_hold", 32'(drop_cnt), 32'd255);

        // watchdog timeout, err_clr, and set-wins
        tick(3);
        tx_auto = 1'b0;
        push_frame(tstamp);
        pulse_force();
        tick(2);
        check("t4_start", 32'(tx_start), 32'd1);
        tick(TO_CYC - 1);
        check("t4_err_early", 32'(timeout_err), 32'd0);
        check("t4_wait_state", 32'(state_dbg), 32'd3);
        tick(1);
        check("t4_err_set", 32'(timeout_err), 32'd1);
        check("t4_idle", 32'(state_dbg), 32'd0);
        check("t4_active", 32'(frame_active), 32'd0);
        check("t4_data_zero", 32'(tx_data), 32'd0);
        exp_q.delete();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_err_clr", 32'(timeout_err), 32'd0);
        push_frame(tstamp);
        pulse_force();
        tick(1 + TO_CYC);
        check("t4_err_early2", 32'(timeout_err), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_set_wins", 32'(timeout_err), 32'd1);
        exp_q.delete();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_err_clr2", 32'(timeout_err), 32'd0);
        tx_auto = 1'b1;
        tick(TX_DLY + 4);

        // asynchronous reset during WAIT of byte 2
        base = starts_seen;
        push_frame(tstamp);
        pulse_force();
        n = 0;
        while (starts_seen < base + 3 && n < 400) begin
            tick(1);
            n++;
        end
        check("t6_reach_b2", 32'(starts_seen), 32'(base + 3));
        tick(3);
        base = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("t6_state", 32'(state_dbg), 32'd0);
        check("t6_active", 32'(frame_active), 32'd0);
        check("t6_tx_data", 32'(tx_data), 32'd0);
        check("t6_tx_start", 32'(tx_start), 32'd0);
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t6_err", 32'(timeout_err), 32'd0);
        exp_q.delete();
        hits = starts_seen;
        tick(2);
        rst_n = 1'b1;
        tick(60);
        check("t6_no_bytes", 32'(starts_seen), 32'(hits));
        check("t6_no_frame", 32'(done_cnt), 32'(base));
        check("t6_idle_after", 32'(frame_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
